// File: rtl/sram_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader: FSM state encoding and default widths.
package sram_burst_reader_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_LEN_W       = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PARK  = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/sram_burst_reader_fifo.sv
// Synchronous FIFO for captured read beats; pointers carry an extra wrap bit so full/empty are exact.
module sram_burst_reader_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_din;
    end

    assign o_count = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/sram_burst_reader.sv
// Burst command to sequential SRAM reads, buffered onto a valid/ready stream.
// Optional WAIT timeout with sticky err is enabled by defining SRAM_TIMEOUT_EN.
module sram_burst_reader
    import sram_burst_reader_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sram_cen,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              sram_ready,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur;
    logic [LEN_W-1:0]  r_rem;
    logic              r_done;
    logic              w_accept;
    logic              w_done_set;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_room;
    logic              w_tmo;
    logic [CW:0]       w_count;
    logic [DATA_W:0]   w_head;

    assign w_push = (r_state == ST_WAIT) && sram_ready;
    assign w_pop  = !w_empty && out_ready;
    // A slot must remain free after this cycle's push/pop to go straight back to REQ.
    assign w_room = (int'(w_count) + 1 - int'(w_pop)) < FIFO_DEPTH;

`ifdef SRAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo = (r_state == ST_WAIT) && !sram_ready && (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT && !sram_ready) r_tmo <= r_tmo + 1'b1;
            else                                  r_tmo <= '0;
            if (w_accept)   r_err <= 1'b0;
            else if (w_tmo) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    sram_burst_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_tmo),
        .i_push  (w_push),
        .i_din   ({sram_rdata, r_rem == LEN_W'(1)}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_next     = r_state;
        sram_cen   = 1'b0;
        sram_addr  = '0;
        w_accept   = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        w_accept = 1'b1;
                        w_next   = ST_PARK;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            ST_PARK: begin
                // Inverted address guarantees the following REQ is seen as a new access.
                sram_addr = ~r_cur;
                if (!w_full) w_next = ST_REQ;
            end
            ST_REQ: begin
                sram_cen  = 1'b1;
                sram_addr = r_cur;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                sram_cen  = 1'b1;
                sram_addr = r_cur;
                if (sram_ready) begin
                    if (r_rem == LEN_W'(1)) w_next = ST_DRAIN;
                    else if (w_room)        w_next = ST_REQ;
                    else                    w_next = ST_PARK;
                end else if (w_tmo) begin
                    w_next     = ST_IDLE;
                    w_done_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_next     = ST_IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            if (w_accept) begin
                r_cur <= base_addr;
                r_rem <= burst_len;
            end else if (w_push) begin
                r_cur <= r_cur + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_head[DATA_W:1];
    assign out_last  = !w_empty && w_head[0];

endmodule
